inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 161 ++++++++++++++++
 tb/tb_inst_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Byte-stream program loader: parses a 16-bit little-endian word-count header,
// assembles little-endian 32-bit words and writes them to instruction memory.
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_wr_en_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] length_q;
    logic [15:0] words_rem_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] word_q;
    logic [31:0] word_addr_q;

    logic        accept;
    logic [15:0] hdr_len;
    logic        len_ok;
    logic        session_start;

    // Ready is a function of state only, so it never depends on byte_valid_i.
    assign accept        = byte_ready_o & byte_valid_i;
    assign hdr_len       = {byte_i, length_q[7:0]};
    assign len_ok        = (hdr_len != 16'd0) && (hdr_len <= MAX_LEN);
    assign session_start = start_i &&
                           (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        byte_ready_o = 1'b0;
        mem_wr_en_o  = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        cpu_hold_o   = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_HDR0;
            end
            S_HDR0: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (accept) state_d = S_HDR1;
            end
            S_HDR1: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (accept) state_d = len_ok ? S_DATA : S_ERR;
            end
            S_DATA: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en_o = 1'b1;
                busy_o      = 1'b1;
                state_d     = (words_rem_q == 16'd1) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done_o     = 1'b1;
                cpu_hold_o = 1'b0;
                if (start_i) state_d = S_HDR0;
            end
            S_ERR: begin
                err_o = 1'b1;
                if (start_i) state_d = S_HDR0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: header capture, word assembly and write-port registers.
    // The write port registers load on the 4th byte so they are valid during
    // WRITE and then simply hold until the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length_q    <= 16'd0;
            words_rem_q <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'd0;
            word_addr_q <= BASE_ADDR;
            mem_addr_o  <= BASE_ADDR;
            mem_data_o  <= 32'd0;
        end else if (session_start) begin
            length_q    <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= 32'd0;
            word_addr_q <= BASE_ADDR;
        end else begin
            case (state_q)
                S_HDR0: begin
                    if (accept) length_q[7:0] <= byte_i;
                end
                S_HDR1: begin
                    if (accept) begin
                        length_q[15:8] <= byte_i;
                        words_rem_q    <= hdr_len;
                        byte_idx_q     <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q[{byte_idx_q, 3'b000} +: 8] <= byte_i;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            mem_data_o <= {byte_i, word_q[23:0]};
                            mem_addr_o <= word_addr_q;
                        end
                    end
                end
                S_WRITE: begin
                    word_addr_q <= word_addr_q + 32'd4;
                    words_rem_q <= words_rem_q - 16'd1;
                    word_q      <= 32'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of header sessions plus
// hand-written sequences, with a write scoreboard fed by the stimulus.
module tb_inst_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wr_en_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       ok;
    } vec_t;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          strobes  = 0;
    int          cyc      = 0;
    int          last_strobe_cyc = 0;
    int          prev_strobe_cyc = 0;
    logic        prev_wr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && mem_wr_en_o) begin
            strobes++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc;
            check("wr_ready_low", {31'd0, byte_ready_o}, 32'd0);
            check("strobe_single", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         mem_addr_o, mem_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_data", mem_data_o, e.data);
            end
        end
        prev_wr = rst_n & mem_wr_en_o;
    end

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Presents a byte and returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (byte_ready_o) begin
                got = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!got) fail_timeout("send_byte");
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 20 && busy_o; n++) @(negedge clk);
        if (busy_o) fail_timeout(name);
    endtask

    // Full session: header, then payload from 'words' (random if empty),
    // optionally with a one-cycle valid gap after every byte.
    task automatic load(input string name, input logic [7:0] lo, input logic [7:0] hi,
                        input logic ok, input logic gap);
        int          base;
        int          len;
        logic [31:0] w;
        len  = int'({hi, lo});
        base = strobes;
        pulse_start();
        check({name, "_start_busy"}, {31'd0, busy_o}, 32'd1);
        check({name, "_start_flags"}, {30'd0, done_o, err_o}, 32'd0);
        send_byte(lo);
        if (gap) idle(1);
        send_byte(hi);
        if (gap) idle(1);
        if (ok) begin
            if (words.size() == 0)
                for (int i = 0; i < len; i++) words.push_back($urandom);
            for (int i = 0; i < len; i++) begin
                w = words[i];
                exp_q.push_back('{addr: BASE + 32'(4 * i), data: w});
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8]);
                    if (gap) idle(1);
                end
            end
        end
        words.delete();
        idle(0);
        wait_idle({name, "_wait"});
        idle(2);
        check({name, "_done"}, {31'd0, done_o}, {31'd0, ok});
        check({name, "_err"}, {31'd0, err_o}, {31'd0, !ok});
        check({name, "_hold"}, {31'd0, cpu_hold_o}, {31'd0, !ok});
        check({name, "_writes"}, 32'(strobes - base), ok ? 32'(len) : 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({name, "_wr"}, {31'd0, mem_wr_en_o}, 32'd0);
        check({name, "_flags"}, {29'd0, busy_o, done_o, err_o}, 32'd0);
        check({name, "_hold"}, {31'd0, cpu_hold_o}, 32'd1);
        check({name, "_addr"}, mem_addr_o, BASE);
        check({name, "_data"}, mem_data_o, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{lo: 8'h00, hi: 8'h00, ok: 1'b0};  // zero length
        vecs[1] = '{lo: 8'h03, hi: 8'h00, ok: 1'b1};
        vecs[2] = '{lo: 8'h01, hi: 8'h01, ok: 1'b0};  // 257 words
        vecs[3] = '{lo: 8'h01, hi: 8'h00, ok: 1'b1};
        vecs[4] = '{lo: 8'h00, hi: 8'hFF, ok: 1'b0};
        vecs[5] = '{lo: 8'h00, hi: 8'h01, ok: 1'b1};  // 256 words, last at 0x3FC
        vecs[6] = '{lo: 8'h05, hi: 8'h00, ok: 1'b1};
        vecs[7] = '{lo: 8'h00, hi: 8'h00, ok: 1'b0};

        rst_n        = 1'b0;
        start_i      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("idle_hold", {31'd0, cpu_hold_o}, 32'd1);

        // Reference program, continuous stream.
        words.push_back(32'h00100513);
        words.push_back(32'h00200593);
        load("ref", 8'h02, 8'h00, 1'b1, 1'b0);
        check("ref_spacing", 32'(last_strobe_cyc - prev_strobe_cyc), 32'd5);

        for (int i = 0; i < 8; i++)
            load($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].ok, 1'b0);

        // Last vector left ERR; a one-word load with toggling valid clears it.
        load("toggle", 8'h01, 8'h00, 1'b1, 1'b1);

        // start_i mid-DATA is ignored; the word completes normally.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        pulse_start();
        check("mid_start_busy", {31'd0, busy_o}, 32'd1);
        check("mid_start_ready", {31'd0, byte_ready_o}, 32'd1);
        exp_q.push_back('{addr: BASE, data: 32'h44332211});
        send_byte(8'h33);
        send_byte(8'h44);
        idle(0);
        wait_idle("mid_start_wait");
        check("mid_start_done", {31'd0, done_o}, 32'd1);
        check("mid_start_sb", 32'(exp_q.size()), 32'd0);

        // Reset after two data bytes aborts the session with no strobe.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_hold", {31'd0, cpu_hold_o}, 32'd1);
        words.push_back(32'hDEADBEEF);
        load("post_rst", 8'h01, 8'h00, 1'b1, 1'b0);

        idle(3);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
